serial_tx_arbiter: RTL and testbench

//  Shares one async_transmitter among NumRequesters byte sources (echo path, status reporter, debug dump).

---
 rtl/serial_pkg.sv | 12 +
 rtl/rr_picker.sv | 28 ++
 rtl/serial_tx_arbiter.sv | 113 +++++++++++
 tb/tb_serial_tx_arbiter.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_pkg.sv
// Shared constants for the serial TX path: FSM encoding, byte width, default start timeout.
package serial_pkg;

  localparam int BYTE_W = 8;
  localparam int START_TIMEOUT_DEFAULT = 7;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_START   = 2'd1;
  localparam logic [1:0] ST_WAIT_HI = 2'd2;
  localparam logic [1:0] ST_WAIT_LO = 2'd3;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping modulo N.
module rr_picker #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [W-1:0] winner,
  output logic         valid
);

  // Scan from the farthest offset down so the nearest requester overwrites the rest.
  always_comb begin
    int idx;
    idx    = 0;
    winner = '0;
    valid  = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      idx = int'(ptr) + i;
      if (idx >= N) idx = idx - N;
      if (req[idx]) begin
        valid  = 1'b1;
        winner = W'(idx);
      end
    end
  end

endmodule

// File: rtl/serial_tx_arbiter.sv
// Round-robin arbiter sharing one async transmitter among several byte sources.
module serial_tx_arbiter
  import serial_pkg::*;
#(
  parameter int NumRequesters = 4,
  parameter int IdWidth       = 2,
  parameter int StartTimeout  = START_TIMEOUT_DEFAULT
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NumRequesters-1:0]        req,
  input  logic [BYTE_W*NumRequesters-1:0] req_data,
  output logic [NumRequesters-1:0]        ack,
  output logic                            tx_start,
  output logic [BYTE_W-1:0]               tx_data,
  input  logic                            tx_busy,
  output logic [IdWidth-1:0]              grant_id,
  output logic                            active,
  output logic                            timeout_err
);

  logic [1:0]               state_reg;
  logic [NumRequesters-1:0] ack_reg;
  logic                     tx_start_reg;
  logic [BYTE_W-1:0]        tx_data_reg;
  logic [IdWidth-1:0]       grant_id_reg;
  logic                     active_reg;
  logic                     timeout_err_reg;
  logic [IdWidth-1:0]       rr_ptr_reg;
  logic [7:0]               timer_reg;

  logic [IdWidth-1:0]       pick_id;
  logic                     pick_valid;
  logic [IdWidth-1:0]       rr_ptr_next;
  logic [BYTE_W-1:0]        byte_arr [NumRequesters];

  for (genvar gi = 0; gi < NumRequesters; gi++) begin : g_unpack
    assign byte_arr[gi] = req_data[BYTE_W*gi +: BYTE_W];
  end

  rr_picker #(
    .N (NumRequesters),
    .W (IdWidth)
  ) u_picker (
    .req    (req),
    .ptr    (rr_ptr_reg),
    .winner (pick_id),
    .valid  (pick_valid)
  );

  assign rr_ptr_next = (pick_id == IdWidth'(NumRequesters - 1)) ? '0 : pick_id + 1'b1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg       <= ST_IDLE;
      ack_reg         <= '0;
      tx_start_reg    <= 1'b0;
      tx_data_reg     <= '0;
      grant_id_reg    <= '0;
      active_reg      <= 1'b0;
      timeout_err_reg <= 1'b0;
      rr_ptr_reg      <= '0;
      timer_reg       <= '0;
    end else begin
      ack_reg      <= '0;
      tx_start_reg <= 1'b0;
      case (state_reg)
        // A busy transmitter here is foreign use or a byte still draining after reset.
        ST_IDLE: begin
          if (pick_valid && !tx_busy) begin
            tx_data_reg  <= byte_arr[pick_id];
            grant_id_reg <= pick_id;
            ack_reg      <= NumRequesters'(1) << pick_id;
            active_reg   <= 1'b1;
            rr_ptr_reg   <= rr_ptr_next;
            state_reg    <= ST_START;
          end
        end
        ST_START: begin
          tx_start_reg <= 1'b1;
          timer_reg    <= 8'(StartTimeout);
          state_reg    <= ST_WAIT_HI;
        end
        ST_WAIT_HI: begin
          if (tx_busy) begin
            state_reg <= ST_WAIT_LO;
          end else if (timer_reg == 8'd0) begin
            timeout_err_reg <= 1'b1;
            active_reg      <= 1'b0;
            state_reg       <= ST_IDLE;
          end else begin
            timer_reg <= timer_reg - 8'd1;
          end
        end
        ST_WAIT_LO: begin
          if (!tx_busy) begin
            active_reg <= 1'b0;
            state_reg  <= ST_IDLE;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign ack         = ack_reg;
  assign tx_start    = tx_start_reg;
  assign tx_data     = tx_data_reg;
  assign grant_id    = grant_id_reg;
  assign active      = active_reg;
  assign timeout_err = timeout_err_reg;

endmodule

// File: tb/tb_serial_tx_arbiter.sv
// Directed bench for serial_tx_arbiter with a simple transmitter model driving tx_busy.
module tb_serial_tx_arbiter;

  localparam int N  = 4;
  localparam int W  = 2;
  localparam int TO = 7;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [N-1:0] req = '0;
  logic [8*N-1:0] req_data = '0;
  logic [N-1:0] ack;
  logic         tx_start;
  logic [7:0]   tx_data;
  logic         tx_busy;
  logic [W-1:0] grant_id;
  logic         active;
  logic         timeout_err;

  int n_tests = 0;
  int n_fail  = 0;

  // Transmitter model: busy for busy_len cycles starting the cycle after tx_start.
  int   busy_cnt = 0;
  int   busy_len = 10;
  logic model_en = 1'b1;
  logic force_busy = 1'b0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (tx_start && model_en) busy_cnt <= busy_len;
    else if (busy_cnt > 0)    busy_cnt <= busy_cnt - 1;
  end
  assign tx_busy = force_busy || (busy_cnt != 0);

  serial_tx_arbiter #(
    .NumRequesters (N),
    .IdWidth       (W),
    .StartTimeout  (TO)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req         (req),
    .req_data    (req_data),
    .ack         (ack),
    .tx_start    (tx_start),
    .tx_data     (tx_data),
    .tx_busy     (tx_busy),
    .grant_id    (grant_id),
    .active      (active),
    .timeout_err (timeout_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset && (ack != '0 || tx_start)) begin
      check("ack_start_exclusive", {31'd0, (ack != '0) && tx_start}, 32'd0);
      check("ack_onehot", {31'd0, $onehot0(ack)}, 32'd1);
    end
  end

  task automatic set_byte(input int i, input logic [7:0] b);
    req_data[8*i +: 8] = b;
  endtask

  // Waits for the next ack, checks the grant, then checks tx_start one cycle later.
  task automatic expect_grant(input string tag, input int exp_id, input logic [7:0] exp_data);
    logic found;
    found = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (ack != '0) begin
        found = 1'b1;
        break;
      end
    end
    if (!found) begin
      check({tag, "_ack_wait"}, 32'd0, 32'd1);
    end else begin
      $display("[TB] %s grant id=%0d data=%h", tag, grant_id, tx_data);
      check({tag, "_id"}, 32'(grant_id), 32'(exp_id));
      check({tag, "_ack"}, 32'(ack), 32'(1 << exp_id));
      check({tag, "_data"}, 32'(tx_data), 32'(exp_data));
      @(negedge clk);
      check({tag, "_start"}, 32'(tx_start), 32'd1);
    end
  endtask

  task automatic wait_done(input string tag);
    logic done;
    done = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!active && !tx_busy) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) check({tag, "_done_wait"}, 32'd0, 32'd1);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_ack"}, 32'(ack), 32'd0);
    check({tag, "_start"}, 32'(tx_start), 32'd0);
    check({tag, "_data"}, 32'(tx_data), 32'h00);
    check({tag, "_gid"}, 32'(grant_id), 32'd0);
    check({tag, "_active"}, 32'(active), 32'd0);
    check({tag, "_terr"}, 32'(timeout_err), 32'd0);
  endtask

  initial begin
    int n;
    int data_bad;
    int ack_seen;
    int start_seen;
    logic [7:0] exp_seq [6];
    int id_seq [6];

    #1;
    check_reset_values("reset");
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Single request: ack at t+1, tx_start at t+2, data held through busy
    set_byte(0, 8'h41);
    req = 4'b0001;
    @(negedge clk);
    $display("[TB] single grant id=%0d data=%h", grant_id, tx_data);
    check("single_ack", 32'(ack), 32'b0001);
    check("single_start_early", 32'(tx_start), 32'd0);
    check("single_active", 32'(active), 32'd1);
    check("single_data", 32'(tx_data), 32'h41);
    req = 4'b0000;
    set_byte(0, 8'hEE);
    @(negedge clk);
    check("single_start", 32'(tx_start), 32'd1);
    check("single_ack_low", 32'(ack), 32'd0);
    n = 0;
    data_bad = 0;
    while (!tx_busy && n < 20) begin
      @(negedge clk);
      n++;
    end
    while (tx_busy && n < 60) begin
      if (tx_data != 8'h41 || !active) data_bad++;
      @(negedge clk);
      n++;
    end
    check("single_hold", 32'(data_bad), 32'd0);
    check("single_active_last", 32'(active), 32'd1);
    @(negedge clk);
    check("single_active_drop", 32'(active), 32'd0);

    // Contention after a fresh reset so rr_ptr starts at 0
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    busy_len = 3;
    set_byte(0, 8'h10);
    set_byte(1, 8'h11);
    set_byte(2, 8'h12);
    set_byte(3, 8'h13);
    req = 4'b1011;
    id_seq  = '{0, 1, 3, 0, 1, 3};
    exp_seq = '{8'h10, 8'h11, 8'h13, 8'h10, 8'h11, 8'h13};
    for (int k = 0; k < 6; k++) begin
      expect_grant($sformatf("rr%0d", k), id_seq[k], exp_seq[k]);
    end
    req = 4'b0000;
    wait_done("rr");

    // Late arrival: source 2 joins while 0 transmits and is served before 0 again
    busy_len = 6;
    set_byte(0, 8'h20);
    req = 4'b0001;
    expect_grant("late0", 0, 8'h20);
    set_byte(0, 8'h21);
    set_byte(2, 8'h22);
    req = 4'b0101;
    expect_grant("late2", 2, 8'h22);
    req = 4'b0001;
    expect_grant("late0b", 0, 8'h21);
    req = 4'b0000;
    wait_done("late");

    // Timeout: busy never rises; error appears StartTimeout+2 cycles after ack
    model_en = 1'b0;
    set_byte(1, 8'h31);
    req = 4'b0010;
    expect_grant("tmo", 1, 8'h31);
    req = 4'b0000;
    n = 1;
    while (!timeout_err && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("tmo_cycles", 32'(n), 32'(TO + 2));
    check("tmo_active", 32'(active), 32'd0);
    model_en = 1'b1;
    set_byte(2, 8'h55);
    req = 4'b0100;
    expect_grant("tmo_next", 2, 8'h55);
    req = 4'b0000;
    wait_done("tmo_next");
    check("tmo_sticky", 32'(timeout_err), 32'd1);

    // Busy in IDLE: no grant while the transmitter is in foreign use
    force_busy = 1'b1;
    set_byte(0, 8'h66);
    req = 4'b0001;
    ack_seen = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (ack != '0) ack_seen++;
    end
    check("busyidle_noack", 32'(ack_seen), 32'd0);
    force_busy = 1'b0;
    expect_grant("busyidle", 0, 8'h66);
    req = 4'b0000;
    wait_done("busyidle");

    // Reset mid-WAIT_LO: outputs clear at once, no start until TX drains
    busy_len = 20;
    set_byte(1, 8'h77);
    req = 4'b0010;
    expect_grant("rst", 1, 8'h77);
    req = 4'b0000;
    n = 0;
    while (!tx_busy && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check_reset_values("rst_async");
    @(negedge clk);
    reset = 1'b0;
    set_byte(0, 8'h88);
    req = 4'b0001;
    ack_seen = 0;
    start_seen = 0;
    n = 0;
    while (tx_busy && n < 60) begin
      if (ack != '0) ack_seen++;
      if (tx_start) start_seen++;
      @(negedge clk);
      n++;
    end
    check("rst_noack_busy", 32'(ack_seen), 32'd0);
    check("rst_nostart_busy", 32'(start_seen), 32'd0);
    expect_grant("rst_after", 0, 8'h88);
    req = 4'b0000;
    wait_done("rst_after");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
